// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - matrix keypad scanner with debounce, multi-key rejection and key FIFO
module keypad_matrix_scanner #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 10000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 8,
    localparam int KW        = $clog2(ROWS*COLS),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [ROWS-1:0]  row_i,
    output logic [COLS-1:0]  col_o,
    output logic [KW-1:0]    key_code_o,
    output logic             key_valid_o,
    input  logic             key_ready_i,
    output logic [CNT_W-1:0] fifo_count_o,
    output logic             overflow_o
);

    localparam int NK = ROWS * COLS;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(COLS);
    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_BLOCKED
    } state_t;

    logic [ROWS-1:0]  r_row_s1;
    logic [ROWS-1:0]  r_row_s2;
    logic [DW-1:0]    r_dwell;
    logic [CW-1:0]    r_col;
    logic [NK-1:0]    r_snap;
    logic             r_eval;
    logic [NK-1:0]    r_prev;
    logic [SW-1:0]    r_stable;
    logic [NK-1:0]    r_deb;
    logic             r_fsm_go;
    state_t           r_state;
    logic [KW-1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic [ROWS-1:0]  w_rows;
    logic             w_last_dwell;
    logic             w_frame_end;
    logic [SW-1:0]    w_stable_nxt;
    logic             w_any;
    logic             w_multi;
    logic [KW-1:0]    w_code;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_wr;

    assign w_rows       = ~r_row_s2;
    assign w_last_dwell = (r_dwell == DW'(SCAN_DIV - 1));
    assign w_frame_end  = w_last_dwell && (r_col == CW'(COLS - 1));
    assign col_o        = ~(COLS'(1) << r_col);

    // Synchroniser, column scan and per-column snapshot capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_row_s1 <= '1;
            r_row_s2 <= '1;
            r_dwell  <= '0;
            r_col    <= '0;
            r_snap   <= '0;
            r_eval   <= 1'b0;
        end else begin
            r_row_s1 <= row_i;
            r_row_s2 <= r_row_s1;
            r_eval   <= w_frame_end;
            if (w_last_dwell) begin
                r_dwell <= '0;
                r_col   <= (r_col == CW'(COLS - 1)) ? '0 : r_col + CW'(1);
            end else begin
                r_dwell <= r_dwell + DW'(1);
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (w_last_dwell && (r_col == CW'(c)))
                        r_snap[r*COLS + c] <= w_rows[r];
                end
            end
        end
    end

    always_comb begin
        w_stable_nxt = SW'(1);
        if (r_snap == r_prev) begin
            if (r_stable >= SW'(DEBOUNCE))
                w_stable_nxt = SW'(DEBOUNCE);
            else
                w_stable_nxt = r_stable + SW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prev   <= '0;
            r_stable <= '0;
            r_deb    <= '0;
            r_fsm_go <= 1'b0;
        end else begin
            r_fsm_go <= r_eval;
            if (r_eval) begin
                r_prev   <= r_snap;
                r_stable <= w_stable_nxt;
                if (w_stable_nxt == SW'(DEBOUNCE))
                    r_deb <= r_snap;
            end
        end
    end

    // Classify the debounced matrix as none / exactly one / several keys
    always_comb begin
        w_any   = 1'b0;
        w_multi = 1'b0;
        w_code  = '0;
        for (int i = 0; i < NK; i++) begin
            if (r_deb[i]) begin
                if (w_any)
                    w_multi = 1'b1;
                w_any  = 1'b1;
                w_code = KW'(i);
            end
        end
    end

    assign w_push = r_fsm_go && (r_state == S_IDLE) && w_any && !w_multi;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else if (r_fsm_go) begin
            case (r_state)
                S_IDLE: begin
                    if (w_multi)
                        r_state <= S_BLOCKED;
                    else if (w_any)
                        r_state <= S_PRESSED;
                end
                S_PRESSED, S_BLOCKED: begin
                    if (!w_any)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_pop  = key_valid_o & key_ready_i;
    assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push overwrites when full
    assign w_wr   = w_push & (!w_full | w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_code;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    assign key_code_o   = r_mem[r_rd_ptr];
    assign key_valid_o  = (r_count != '0);
    assign fifo_count_o = r_count;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - self-checking bench for keypad_matrix_scanner
module tb_keypad_matrix_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int FRAME = 16;
    localparam int NVEC  = 9;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic [3:0]  key_code_o;
    logic        key_valid_o;
    logic        key_ready_i;
    logic [2:0]  fifo_count_o;
    logic        overflow_o;

    logic [15:0] keys;
    int          cyc;
    int          n_cmp;
    int          n_err;

    typedef struct {
        logic [15:0] mask;
        int          hold;
        int          rel;
        int          exp_cnt;
        int          exp_code;
    } vec_t;

    vec_t tbl [NVEC];

    keypad_matrix_scanner #(
        .ROWS       (4),
        .COLS       (4),
        .SCAN_DIV   (4),
        .DEBOUNCE   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .row_i        (row_i),
        .col_o        (col_o),
        .key_code_o   (key_code_o),
        .key_valid_o  (key_valid_o),
        .key_ready_i  (key_ready_i),
        .fifo_count_o (fifo_count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key pulls its row low while its column is driven low
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            row_i[r] = ~|(keys[r*COLS +: COLS] & ~col_o);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        cyc   = 0;
    endtask

    task automatic press_seq(input logic [15:0] mask, input int hold, input int rel);
        keys = mask;
        tick(hold * FRAME);
        keys = '0;
        tick(rel * FRAME);
    endtask

    task automatic pop_check(input string name, input int exp_code);
        check({name, " valid"}, key_valid_o, 1);
        check({name, " code"}, key_code_o, exp_code);
        key_ready_i = 1'b1;
        tick(1);
        key_ready_i = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        cyc         = 0;
        keys        = '0;
        key_ready_i = 1'b0;
        rst_i       = 1'b1;

        tbl[0] = '{16'h0200, 3, 4, 1, 9};
        tbl[1] = '{16'h0001, 6, 4, 1, 0};
        tbl[2] = '{16'h8000, 4, 4, 1, 15};
        tbl[3] = '{16'h0040, 2, 4, 0, 0};
        tbl[4] = '{16'h0041, 5, 4, 0, 0};
        tbl[5] = '{16'h0008, 3, 4, 1, 3};
        tbl[6] = '{16'h0030, 4, 4, 0, 0};
        tbl[7] = '{16'h2002, 4, 4, 0, 0};
        tbl[8] = '{16'h0000, 4, 2, 0, 0};

        // Reset values and first column advance
        do_reset();
        check("rst col", col_o, 4'b1110);
        check("rst valid", key_valid_o, 0);
        check("rst count", fifo_count_o, 0);
        check("rst overflow", overflow_o, 0);
        check("rst code", key_code_o, 0);
        tick(3);
        check("col cyc3", col_o, 4'b1110);
        tick(1);
        check("col cyc4", col_o, 4'b1101);

        for (int i = 0; i < NVEC; i++) begin
            keys = '0;
            do_reset();
            press_seq(tbl[i].mask, tbl[i].hold, tbl[i].rel);
            check($sformatf("vec%0d count", i), fifo_count_o, tbl[i].exp_cnt);
            check($sformatf("vec%0d valid", i), key_valid_o, (tbl[i].exp_cnt != 0) ? 1 : 0);
            if (tbl[i].exp_cnt != 0)
                check($sformatf("vec%0d code", i), key_code_o, tbl[i].exp_code);
        end

        // Single press: valid rises exactly at frame_end(frame 2) + 3 = cycle 50
        keys = '0;
        do_reset();
        keys = 16'h0200;
        tick(49);
        check("single valid@49", key_valid_o, 0);
        tick(1);
        check("single valid@50", key_valid_o, 1);
        check("single code", key_code_o, 9);
        check("single count", fifo_count_o, 1);
        tick(96 - 50);
        keys = '0;
        tick(4 * FRAME);
        check("single no repeat", fifo_count_o, 1);
        key_ready_i = 1'b1;
        tick(1);
        key_ready_i = 1'b0;
        check("single popped valid", key_valid_o, 0);
        check("single popped count", fifo_count_o, 0);

        // Bounce: toggled every frame never settles
        do_reset();
        for (int f = 0; f < 6; f++) begin
            keys = (f % 2 == 0) ? 16'h0008 : 16'h0000;
            tick(FRAME);
        end
        keys = '0;
        tick(4 * FRAME);
        check("bounce count", fifo_count_o, 0);

        // Multi-key blocked, then a clean press after release
        do_reset();
        press_seq(16'h0041, 5, 4);
        check("multi none", fifo_count_o, 0);
        press_seq(16'h8000, 4, 4);
        check("multi then count", fifo_count_o, 1);
        check("multi then code", key_code_o, 15);

        // Overflow with ready held low
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            press_seq(16'h0001 << i, 3, 4);
            if (i == 4) begin
                check("ovf count4", fifo_count_o, 4);
                check("ovf flag4", overflow_o, 0);
            end
        end
        check("ovf count5", fifo_count_o, 4);
        check("ovf flag5", overflow_o, 1);
        for (int k = 1; k <= 4; k++)
            pop_check($sformatf("ovf pop%0d", k), k);
        check("ovf drained", key_valid_o, 0);
        check("ovf sticky", overflow_o, 1);

        // Reset in the middle of a debounce
        keys = 16'h0020;
        do_reset();
        tick(2 * FRAME);
        do_reset();
        check("midrst overflow", overflow_o, 0);
        check("midrst col", col_o, 4'b1110);
        tick(2 * FRAME);
        keys = '0;
        tick(4 * FRAME);
        check("midrst count", fifo_count_o, 0);

        // Full FIFO with a pop on the push edge
        keys = '0;
        do_reset();
        for (int i = 1; i <= 4; i++)
            press_seq(16'h0001 << i, 3, 3);
        check("fullpop pre count", fifo_count_o, 4);
        keys = 16'h0020;
        tick(49);
        check("fullpop before push", fifo_count_o, 4);
        key_ready_i = 1'b1;
        tick(1);
        key_ready_i = 1'b0;
        check("fullpop count", fifo_count_o, 4);
        check("fullpop overflow", overflow_o, 0);
        for (int k = 2; k <= 5; k++)
            pop_check($sformatf("fullpop pop%0d", k), k);
        check("fullpop drained", key_valid_o, 0);
        keys = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
